softmax_stream_unit: RTL and testbench
======================================

// Module: softmax_stream_unit
// PURPOSE
//  Parametrised LANES-wide fixed-point softmax for the special-function path.
//  Accepts one signed vector per valid/ready handshake. Computes a base-2 softmax:
//  max reduction, piecewise-linear exp2, sum, then a shared sequential divider.
//  Drives one unsigned probability vector downstream, held until accepted.
// PARAMETERS
//  LANES   8   vector elements per transaction (>=2)
//  DATA_W  16  signed input width, two's complement
//  FRAC_W  8   input fractional bits (<=14)
//  OUT_W   16  unsigned output width, Q0.OUT_W
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             synchronous, active-high reset
//  in_data    in   LANES*DATA_W  lane i = bits [i*DATA_W +: DATA_W]
//  in_mask    in   LANES         lane enable; present only with SOFTMAX_MASK_EN
//  in_valid   in   1             input vector valid
//  in_ready   out  1             high only in IDLE
//  out_data   out  LANES*OUT_W   lane i = bits [i*OUT_W +: OUT_W]
//  out_valid  out  1             result vector valid
//  out_ready  in   1             downstream accept
//  busy       out  1             high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, internal regs=0.
//   Reset applies mid-operation; no partial result escapes.
//  FSM: IDLE -> MAX -> EXP -> SUM -> NORM -> OUT -> IDLE.
//  IDLE: on in_valid&&in_ready, register in_data (and in_mask) -> MAX. Call this cycle 0.
//  MAX (1 cycle): signed max over the registered lanes; tie choice does not matter.
//  EXP (1 cycle): m=max-x_i (>=0, DATA_W+1 bits); ip=m>>FRAC_W; fp=m[FRAC_W-1:0].
//   mant=16'h8000-(fp<<(14-FRAC_W)), which is 2^-f ~ 1-f/2 in Q1.15.
//   e_i = (ip>=16) ? 0 : mant>>ip. e_i is 16-bit unsigned Q1.15.
//  SUM (1 cycle): S = sum of e_i, width 16+$clog2(LANES); no overflow possible.
//  NORM: one restoring divider, shared, processes lanes in order 0..LANES-1.
//   Each lane takes OUT_W+2 cycles: 1 load cycle + OUT_W+1 quotient-bit cycles.
//   q = floor(e_i*2^OUT_W / S); q>=2^OUT_W saturates to 2^OUT_W-1.
//   Lane result is written to its out_data slice when that lane finishes.
//  Latency: out_valid rises in cycle 4+LANES*(OUT_W+2). Defaults: 148.
//  OUT: out_valid=1; out_data is stable while out_valid&&!out_ready.
//   On out_valid&&out_ready: out_valid=0 next cycle, state -> IDLE.
//   out_data keeps its value until the next NORM overwrites it.
//  in_valid is ignored while busy; no input is queued.
//   The earliest next accept is the cycle after the output handshake.
//  in_ready and busy are registered; in_ready == !busy at all times.
//  Inputs are not required to be held after the accept cycle.
// CONFIGURATION
//  SOFTMAX_MASK_EN defined:
//   - in_mask port exists and is registered with in_data.
//   - Masked lanes (bit=0) are excluded from MAX, force e_i=0, and output 0.
//   - All lanes masked: S=0, divider skipped per lane; all outputs 0, same latency.
//  SOFTMAX_MASK_EN undefined:
//   - No in_mask port; every lane is enabled.
// TESTING (defaults, FRAC_W=8)
//  1 All lanes 16'h0000 -> each e=16'h8000, S=18'h40000, each out 16'h2000.
//    out_valid exactly 148 cycles after accept.
//  2 lane0=16'h0000, lanes1-7=16'hF000 (-16.0) -> lanes1-7 e=0.
//    out0=16'hFFFF (saturated), others 16'h0000.
//  3 lane0=16'h0100 (1.0), others 0 -> e=8000/4000, S=18'h24000.
//    out0=16'h38E3, others 16'h1C71.
//  4 out_ready low for 20 cycles -> out_valid and out_data stable, in_ready=0.
//    in_valid pulses ignored; single handshake, then in_ready=1 next cycle.
//  5 rst pulse during NORM -> next cycle out_valid=0, in_ready=1, busy=0, out_data=0.
//    A following vector produces a correct result.
//  6 MASK_EN: equal inputs, mask=8'h0F -> lanes0-3 16'h4000, lanes4-7 0.
//    mask=8'h00 -> all outputs 0, latency 148.

Source files
------------

// File: rtl/softmax_stream_unit.sv
// softmax_stream_unit: LANES-wide base-2 fixed-point softmax with a shared sequential divider
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready input vector stream;
//  in_mask lane enable (only with SOFTMAX_MASK_EN); out_data/out_valid/out_ready result
//  stream held until accepted; busy high whenever not idle.
// Optional feature macro: SOFTMAX_MASK_EN (per-lane masking).
module softmax_stream_unit #(
  parameter int LANES  = 8,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*DATA_W-1:0]   in_data,
`ifdef SOFTMAX_MASK_EN
  input  logic [LANES-1:0]          in_mask,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [LANES*OUT_W-1:0]    out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);
  localparam int LW = $clog2(LANES);
  localparam int SW = 16 + LW;
  localparam int RW = SW + 1;
  localparam int CW = $clog2(OUT_W + 2);
  localparam int XW = DATA_W + 1;
  typedef enum logic [2:0] {IDLE, MAX, EXP, SUM, NORM, OUT} state_t;
  state_t state_q, state_d;
  logic in_ready_q, busy_q, out_valid_q;
  logic [LANES*OUT_W-1:0] out_q;
  logic signed [DATA_W-1:0] x_q [LANES];
  logic signed [DATA_W-1:0] max_q, mx;
  logic [15:0] e_q [LANES];
  logic [15:0] e_d [LANES];
  logic [15:0] mant [LANES];
  logic [XW-1:0] m [LANES];
  logic [SW-1:0] s_q, s_d;
  logic [RW-1:0] r_q, diff;
  logic [OUT_W-1:0] q_q, res;
  logic [OUT_W:0] qf;
  logic ge;
  logic [LW-1:0] lane_q;
  logic [CW-1:0] cnt_q;
  logic [LANES-1:0] en;
  logic accept;
`ifdef SOFTMAX_MASK_EN
  logic [LANES-1:0] mask_q;
  assign en = mask_q;
`else
  assign en = '1;
`endif
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign accept    = state_q == IDLE && in_valid && in_ready_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? MAX : IDLE;
      MAX:     state_d = EXP;
      EXP:     state_d = SUM;
      SUM:     state_d = NORM;
      NORM:    state_d = (cnt_q == CW'(OUT_W + 1) && lane_q == LW'(LANES - 1)) ? OUT : NORM;
      OUT:     state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  // Masked lanes never win the max; start from the most negative value.
  always_comb begin
    mx = {1'b1, {(DATA_W-1){1'b0}}};
    for (int i = 0; i < LANES; i++) mx = (en[i] && x_q[i] > mx) ? x_q[i] : mx;
  end
  // 2^-(ip+fp) ~ (1 - fp/2) >> ip in Q1.15; beyond 15 integer steps the value underflows to 0.
  always_comb begin
    s_d = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i]    = XW'(max_q) - XW'(x_q[i]);
      mant[i] = 16'h8000 - (16'(m[i][FRAC_W-1:0]) << (14 - FRAC_W));
      e_d[i]  = (!en[i] || (m[i] >> FRAC_W) >= XW'(16)) ? 16'd0 : mant[i] >> (m[i] >> FRAC_W);
      s_d     = s_d + SW'(e_q[i]);
    end
  end
  // Restoring division step; e <= S so the quotient fits OUT_W+1 bits and only e==S saturates.
  always_comb begin
    ge   = r_q >= RW'(s_q);
    diff = ge ? r_q - RW'(s_q) : r_q;
    qf   = {q_q, ge};
    res  = (s_q == '0) ? '0 : qf[OUT_W] ? '1 : qf[OUT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      max_q       <= '0;
      s_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      lane_q      <= '0;
      cnt_q       <= '0;
`ifdef SOFTMAX_MASK_EN
      mask_q      <= '0;
`endif
      for (int i = 0; i < LANES; i++) begin
        x_q[i] <= '0;
        e_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_ready_q  <= state_d == IDLE;
      busy_q      <= state_d != IDLE;
      out_valid_q <= state_d == OUT;
      if (accept) begin
        for (int i = 0; i < LANES; i++) x_q[i] <= in_data[i*DATA_W +: DATA_W];
`ifdef SOFTMAX_MASK_EN
        mask_q <= in_mask;
`endif
        lane_q <= '0;
        cnt_q  <= '0;
      end
      if (state_q == MAX) max_q <= mx;
      if (state_q == EXP) for (int i = 0; i < LANES; i++) e_q[i] <= e_d[i];
      if (state_q == SUM) s_q <= s_d;
      if (state_q == NORM) begin
        if (cnt_q == '0) begin
          r_q   <= RW'(e_q[lane_q]);
          q_q   <= '0;
          cnt_q <= cnt_q + 1'b1;
        end else if (cnt_q == CW'(OUT_W + 1)) begin
          out_q[lane_q*OUT_W +: OUT_W] <= res;
          cnt_q  <= '0;
          lane_q <= lane_q + 1'b1;
        end else begin
          r_q   <= diff << 1;
          q_q   <= qf[OUT_W-1:0];
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_softmax_stream_unit.sv
// tb_softmax_stream_unit: randomized self-checking bench for softmax_stream_unit against an arithmetic softmax model
module tb_softmax_stream_unit;
  localparam int LAT = 148;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;
  logic [7:0] mask_v = 8'hFF;
`ifdef SOFTMAX_MASK_EN
  logic [7:0] in_mask;
`endif
  int total = 0;
  int bad = 0;
  softmax_stream_unit dut (
    .clk(clk), .rst(rst), .in_data(in_data),
`ifdef SOFTMAX_MASK_EN
    .in_mask(in_mask),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [127:0] model(input logic [127:0] d, input logic [7:0] mk);
    int x [8];
    longint e [8];
    int mx, mm, ip, fp;
    longint s, q;
    logic [127:0] r;
    mx = -100000;
    s = 0;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      x[i] = int'($signed(d[i*16 +: 16]));
      if (mk[i] && x[i] > mx) mx = x[i];
    end
    for (int i = 0; i < 8; i++) begin
      mm = mx - x[i];
      ip = mm / 256;
      fp = mm % 256;
      e[i] = (!mk[i] || ip >= 16) ? 0 : longint'(32768 - fp * 64) / (longint'(1) << ip);
      s += e[i];
    end
    for (int i = 0; i < 8; i++) begin
      q = (s == 0) ? 0 : (e[i] * 65536) / s;
      if (q > 65535) q = 65535;
      r[i*16 +: 16] = q[15:0];
    end
    return r;
  endfunction
  task automatic send(input logic [127:0] d);
    int g = 0;
    in_data = d;
`ifdef SOFTMAX_MASK_EN
    in_mask = mask_v;
`endif
    in_valid = 1'b1;
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  function automatic logic [127:0] rand_vec();
    logic [127:0] v;
    for (int i = 0; i < 8; i++)
      v[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095) - 2048);
    return v;
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0) begin
      bad++;
      $display("FAIL reset: got rdy/vld/busy=%b data=%h, want 100 data=0", {in_ready, out_valid, busy}, out_data);
    end
  endtask
  task automatic test_vector(input string nm, input logic [127:0] d, input logic [127:0] want);
    int lat;
    send(d);
    wait_out(lat);
    total++;
    if (lat != LAT) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, LAT);
    end
    total++;
    if (out_data !== want) begin
      bad++;
      $display("FAIL %s data: got %h want %h", nm, out_data, want);
    end
    accept();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s handshake: got vld=%b rdy=%b want 0 1", nm, out_valid, in_ready);
    end
  endtask
  task automatic test_random();
    logic [127:0] d;
    for (int n = 0; n < 6; n++) begin
      d = rand_vec();
      test_vector("random", d, model(d, mask_v));
    end
  endtask
  task automatic test_backpressure();
    logic [127:0] d, want;
    int lat;
    d = rand_vec();
    want = model(d, mask_v);
    send(d);
    wait_out(lat);
    total++;
    if (lat != LAT) begin
      bad++;
      $display("FAIL backpressure latency: got %0d want %0d", lat, LAT);
    end
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      in_data = rand_vec();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_data !== want) begin
        bad++;
        $display("FAIL backpressure hold %0d: got vld=%b rdy=%b busy=%b data=%h want 1 0 1 %h",
                 c, out_valid, in_ready, busy, out_data, want);
      end
    end
    in_valid = 1'b0;
    accept();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL backpressure release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== want) begin
      bad++;
      $display("FAIL backpressure no-queue: got busy=%b vld=%b data=%h want 0 0 %h", busy, out_valid, out_data, want);
    end
  endtask
  task automatic test_reset_mid();
    send(rand_vec());
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_mid: got rdy/vld/busy=%b data=%h want 100 data=0", {in_ready, out_valid, busy}, out_data);
    end
    test_vector("after_reset", {{7{16'h0000}}, 16'h0100}, {{7{16'h1C71}}, 16'h38E3});
  endtask
  task automatic test_mask();
`ifdef SOFTMAX_MASK_EN
    mask_v = 8'h0F;
    test_vector("mask_0F", {8{16'h0100}}, {{4{16'h0000}}, {4{16'h4000}}});
    mask_v = 8'h00;
    test_vector("mask_00", {8{16'h0100}}, '0);
    for (int n = 0; n < 3; n++) begin
      logic [127:0] d;
      mask_v = 8'($urandom);
      d = rand_vec();
      test_vector("mask_rand", d, model(d, mask_v));
    end
    mask_v = 8'hFF;
`endif
  endtask
  initial begin
    test_reset();
    test_vector("uniform", '0, {8{16'h2000}});
    test_vector("saturate", {{7{16'hF000}}, 16'h0000}, {{7{16'h0000}}, 16'hFFFF});
    test_vector("onehot", {{7{16'h0000}}, 16'h0100}, {{7{16'h1C71}}, 16'h38E3});
    test_random();
    test_backpressure();
    test_reset_mid();
    test_mask();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
